// File: rtl/us_ranger_pkg.sv
// rtl/us_ranger_pkg.sv - shared states and constants for the ultrasonic ranging sequencer
package us_ranger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEAS,
    HOLDOFF
  } state_e;

  localparam int unsigned US_PER_CM = 58;

  // All-ones distance code reserved for "no target"
  function automatic int unsigned cm_none(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/us_ranger_seq_if.sv
// rtl/us_ranger_seq_if.sv - sensor pins and result bus of the ranging sequencer
interface us_ranger_seq_if #(
  parameter int N_CH = 4,
  parameter int CM_W = 11,
  parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0] echo;
  logic [N_CH-1:0] trig;
  logic            dist_valid;
  logic [CH_W-1:0] dist_ch;
  logic [CM_W-1:0] dist_cm;
  logic            dist_timeout;

  modport master (
    input  echo,
    output trig,
    output dist_valid,
    output dist_ch,
    output dist_cm,
    output dist_timeout
  );

  modport slave (
    output echo,
    input  trig,
    input  dist_valid,
    input  dist_ch,
    input  dist_cm,
    input  dist_timeout
  );
endinterface

// File: rtl/us_echo_sync.sv
// rtl/us_echo_sync.sv - per-channel 2-FF echo synchroniser with registered edge pulses
module us_echo_sync #(
  parameter int N_CH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] echo_i,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);
  logic [N_CH-1:0] meta_q;
  logic [N_CH-1:0] sync_q;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] rise_q;
  logic [N_CH-1:0] fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      meta_q <= echo_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/us_ranger_seq.sv
// rtl/us_ranger_seq.sv - round-robin multi-channel ultrasonic ranging sequencer
module us_ranger_seq
  import us_ranger_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CLK_PER_US = 1,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 38000,
  parameter int HOLDOFF_US = 60000,
  parameter int CM_W       = 11
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic [N_CH-1:0] ch_mask_i,
  output logic            busy_o,
  us_ranger_seq_if.master bus
);
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int MAX_TH  = (TIMEOUT_US > HOLDOFF_US) ? TIMEOUT_US : HOLDOFF_US;
  localparam int CNT_MAX = (MAX_TH > TRIG_US) ? MAX_TH : TRIG_US;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] HO_LAST   = CNT_W'(HOLDOFF_US - 1);
  localparam logic [5:0]       SUB_LAST  = 6'(US_PER_CM - 1);
  localparam logic [CM_W-1:0]  CM_NONE   = CM_W'(cm_none(CM_W));
  localparam logic [CM_W-1:0]  CM_SAT    = CM_W'(cm_none(CM_W) - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]      sub_q, sub_d;
  logic [CM_W-1:0] cm_q, cm_d;
  logic            dv_q, dv_d;
  logic [CH_W-1:0] dch_q, dch_d;
  logic [CM_W-1:0] dcm_q, dcm_d;
  logic            dto_q, dto_d;

  logic            us_tick;
  logic [N_CH-1:0] rise, fall;
  logic            rise_sel, fall_sel;
  logic [CNT_W-1:0] cnt_inc;
  logic [CH_W-1:0] nxt_ptr;
  logic            sub_wrap;
  logic [5:0]      sub_adv;
  logic [CM_W-1:0] cm_adv;
  logic [N_CH-1:0] trig_vec;

  // Ticks are aligned to clk edges so a trigger started on a tick lasts whole microseconds
  if (CLK_PER_US == 1) begin : g_nopre
    assign us_tick = 1'b1;
  end else begin : g_pre
    localparam int PW = $clog2(CLK_PER_US);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
    logic [PW-1:0] pre_q;
    always_ff @(posedge clk_i) begin
      if (rst_i || pre_q == PRE_LAST) pre_q <= '0;
      else                            pre_q <= pre_q + 1'b1;
    end
    assign us_tick = (pre_q == PRE_LAST);
  end

  us_echo_sync #(.N_CH(N_CH)) u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .echo_i (bus.echo),
    .rise_o (rise),
    .fall_o (fall)
  );

  function automatic logic [CH_W-1:0] next_ch(input logic [N_CH-1:0] mask,
                                              input logic [CH_W-1:0] start);
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] j;
    logic            found;
    r = start;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      j = CH_W'((int'(start) + k) % N_CH);
      if (!found && mask[j]) begin
        r = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign rise_sel = rise[ch_q];
  assign fall_sel = fall[ch_q];
  assign cnt_inc  = cnt_q + 1'b1;
  assign nxt_ptr  = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
  assign sub_wrap = us_tick && (sub_q == SUB_LAST);
  assign sub_adv  = !us_tick ? sub_q : (sub_wrap ? 6'd0 : sub_q + 6'd1);
  assign cm_adv   = (sub_wrap && cm_q != CM_SAT) ? cm_q + 1'b1 : cm_q;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    dv_d    = 1'b0;
    dch_d   = dch_q;
    dcm_d   = dcm_q;
    dto_d   = dto_q;
    case (state_q)
      IDLE: begin
        if (en_i && (|ch_mask_i) && us_tick) begin
          ch_d    = next_ch(ch_mask_i, ptr_q);
          cnt_d   = '0;
          state_d = TRIG;
        end
      end
      TRIG: begin
        if (us_tick) begin
          if (cnt_q == TRIG_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_RISE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      WAIT_RISE: begin
        if (rise_sel) begin
          cnt_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
          state_d = MEAS;
        end else if (us_tick) begin
          if (cnt_q == TO_LAST) begin
            dv_d    = 1'b1;
            dch_d   = ch_q;
            dcm_d   = CM_NONE;
            dto_d   = 1'b1;
            cnt_d   = '0;
            state_d = HOLDOFF;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      MEAS: begin
        // The tick landing on the fall edge still counts toward the width
        if (us_tick && cnt_q == TO_LAST) begin
          dv_d    = 1'b1;
          dch_d   = ch_q;
          dcm_d   = CM_NONE;
          dto_d   = 1'b1;
          cnt_d   = '0;
          state_d = HOLDOFF;
        end else if (fall_sel) begin
          dv_d    = 1'b1;
          dch_d   = ch_q;
          dcm_d   = cm_adv;
          dto_d   = 1'b0;
          cnt_d   = '0;
          state_d = HOLDOFF;
        end else if (us_tick) begin
          cnt_d = cnt_inc;
          sub_d = sub_adv;
          cm_d  = cm_adv;
        end
      end
      HOLDOFF: begin
        if (us_tick) begin
          if (cnt_q == HO_LAST) begin
            cnt_d = '0;
            ptr_d = nxt_ptr;
            if (en_i && (|ch_mask_i)) begin
              ch_d    = next_ch(ch_mask_i, nxt_ptr);
              state_d = TRIG;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ch_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      dv_q    <= 1'b0;
      dch_q   <= '0;
      dcm_q   <= '0;
      dto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      dv_q    <= dv_d;
      dch_q   <= dch_d;
      dcm_q   <= dcm_d;
      dto_q   <= dto_d;
    end
  end

  always_comb begin
    trig_vec = '0;
    if (state_q == TRIG) trig_vec[ch_q] = 1'b1;
  end

  assign bus.trig         = trig_vec;
  assign bus.dist_valid   = dv_q;
  assign bus.dist_ch      = dch_q;
  assign bus.dist_cm      = dcm_q;
  assign bus.dist_timeout = dto_q;
  assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_us_ranger_seq.sv
// tb/tb_us_ranger_seq.sv - directed vector bench for the ultrasonic ranging sequencer
module tb_us_ranger_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic [3:0] mask_a, mask_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  us_ranger_seq_if #(.N_CH(4), .CM_W(11)) a_if ();
  us_ranger_seq_if #(.N_CH(4), .CM_W(11)) b_if ();

  us_ranger_seq #(.N_CH(4), .CLK_PER_US(1), .TRIG_US(10), .TIMEOUT_US(38000),
                  .HOLDOFF_US(1000), .CM_W(11)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en_a), .ch_mask_i(mask_a), .busy_o(busy_a), .bus(a_if)
  );

  us_ranger_seq #(.N_CH(4), .CLK_PER_US(4), .TRIG_US(10), .TIMEOUT_US(38000),
                  .HOLDOFF_US(1000), .CM_W(11)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en_b), .ch_mask_i(mask_b), .busy_o(busy_b), .bus(b_if)
  );

  typedef struct {
    logic [3:0] mask;
    logic [3:0] pulse;
    int         width;
    bit         pre_high;
    int         exp_ch;
    int         exp_cm;
    bit         exp_to;
  } vec_t;

  vec_t v[11];
  int   passed = 0;
  int   total = 0;
  int   n, w, s0, t0;
  logic [3:0] tr;

  int   onehot_err = 0;
  int   strobes = 0;
  int   trig_rises = 0;
  int   bad13 = 0;
  bit   watch13 = 1'b0;
  logic any_trig_prev = 1'b0;

  always @(negedge clk) begin
    if (!$onehot0(a_if.trig)) onehot_err++;
    if (a_if.dist_valid) strobes++;
    if ((|a_if.trig) && !any_trig_prev) trig_rises++;
    any_trig_prev = |a_if.trig;
    if (watch13 && (a_if.trig[1] || a_if.trig[3])) bad13++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_trig_a(input int bound);
    n = 0;
    while (a_if.trig == 4'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic trig_width_a();
    w = 0;
    while (a_if.trig != 4'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
  endtask

  initial begin
    v[0]  = '{4'b0001, 4'b0001, 5900, 1'b0, 0, 101, 1'b0};
    v[1]  = '{4'b0001, 4'b0001,   57, 1'b0, 0,   0, 1'b0};
    v[2]  = '{4'b0001, 4'b0001,   58, 1'b0, 0,   1, 1'b0};
    v[3]  = '{4'b0001, 4'b0001,  116, 1'b0, 0,   2, 1'b0};
    v[4]  = '{4'b0101, 4'b1111,  200, 1'b0, 2,   3, 1'b0};
    v[5]  = '{4'b0101, 4'b1111,  300, 1'b0, 0,   5, 1'b0};
    v[6]  = '{4'b0101, 4'b1111,  580, 1'b0, 2,  10, 1'b0};
    v[7]  = '{4'b0101, 4'b1111, 1000, 1'b0, 0,  17, 1'b0};
    v[8]  = '{4'b1111, 4'b0010,   59, 1'b0, 1,   1, 1'b0};
    v[9]  = '{4'b1000, 4'b1000,    1, 1'b0, 3,   0, 1'b0};
    v[10] = '{4'b0010, 4'b0010,    0, 1'b1, 1, 2047, 1'b1};

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; mask_a = 4'b0; mask_b = 4'b0;
    a_if.echo = 4'b0; b_if.echo = 4'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy_a, 0);
    check("reset_trig", a_if.trig, 0);
    check("reset_valid", a_if.dist_valid, 0);
    check("reset_cm", a_if.dist_cm, 0);
    check("reset_ch", a_if.dist_ch, 0);
    check("reset_timeout", a_if.dist_timeout, 0);
    rst = 1'b0;

    // Trigger width with a 4-clock microsecond
    en_b = 1'b1; mask_b = 4'b0001;
    n = 0;
    while (b_if.trig == 4'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("x4_trig_sel", b_if.trig, 1);
    w = 0;
    while (b_if.trig != 4'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("x4_trig_width", w, 40);
    en_b = 1'b0;

    en_a = 1'b1; mask_a = 4'b0;
    repeat (20) @(negedge clk);
    check("idle_mask0_busy", busy_a, 0);

    for (int i = 0; i < 11; i++) begin
      watch13 = (v[i].mask == 4'b0101);
      mask_a = v[i].mask;
      if (v[i].pre_high) a_if.echo = v[i].pulse;
      wait_trig_a(1500);
      tr = a_if.trig;
      check($sformatf("v%0d_trig_sel", i), tr, 1 << v[i].exp_ch);
      trig_width_a();
      check($sformatf("v%0d_trig_width", i), w, 10);
      if (v[i].exp_to) begin
        s0 = strobes;
        n = 0;
        while (!a_if.dist_valid && n < 40000) begin
          @(negedge clk);
          n++;
          if (n == 100) a_if.echo = 4'b0;
        end
        check($sformatf("v%0d_timeout_latency", i), n, 38000);
      end else begin
        repeat (20) @(negedge clk);
        a_if.echo = v[i].pulse;
        repeat (v[i].width) @(negedge clk);
        a_if.echo = 4'b0;
        s0 = strobes;
        n = 0;
        while (!a_if.dist_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("v%0d_fall_latency", i), n, 4);
      end
      check($sformatf("v%0d_dist_ch", i), a_if.dist_ch, v[i].exp_ch);
      check($sformatf("v%0d_dist_cm", i), a_if.dist_cm, v[i].exp_cm);
      check($sformatf("v%0d_timeout", i), a_if.dist_timeout, v[i].exp_to);
      repeat (10) @(negedge clk);
      check($sformatf("v%0d_single_strobe", i), strobes - s0, 1);
      check($sformatf("v%0d_held_cm", i), a_if.dist_cm, v[i].exp_cm);
    end
    watch13 = 1'b0;
    check("trig13_never", bad13, 0);

    // en dropped mid-measurement: result still posted, then idle after holdoff
    mask_a = 4'b0001;
    wait_trig_a(1500);
    check("enlow_trig_sel", a_if.trig, 1);
    trig_width_a();
    repeat (20) @(negedge clk);
    a_if.echo = 4'b0001;
    repeat (100) @(negedge clk);
    en_a = 1'b0;
    repeat (190) @(negedge clk);
    a_if.echo = 4'b0;
    n = 0;
    while (!a_if.dist_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("enlow_valid", a_if.dist_valid, 1);
    check("enlow_cm", a_if.dist_cm, 5);
    check("enlow_timeout", a_if.dist_timeout, 0);
    t0 = trig_rises;
    n = 0;
    while (busy_a && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("enlow_idle_after", n, 1000);
    repeat (50) @(negedge clk);
    check("enlow_stays_idle", busy_a, 0);
    check("enlow_no_retrig", trig_rises - t0, 0);

    // Reset in the middle of a measurement
    en_a = 1'b1;
    wait_trig_a(100);
    trig_width_a();
    repeat (20) @(negedge clk);
    a_if.echo = 4'b0001;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    s0 = strobes;
    @(negedge clk);
    check("rst_meas_trig", a_if.trig, 0);
    check("rst_meas_busy", busy_a, 0);
    check("rst_meas_valid", a_if.dist_valid, 0);
    check("rst_meas_cm", a_if.dist_cm, 0);
    rst = 1'b0; en_a = 1'b0; a_if.echo = 4'b0;
    repeat (30) @(negedge clk);
    check("rst_meas_no_strobe", strobes - s0, 0);
    check("rst_meas_idle", busy_a, 0);

    check("trig_onehot", onehot_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
